// File: rtl/arbiter.sv
// Round-robin merge of ninputs valid/ready streams into a single output stream.
// Each accepted message is tagged with its source index in the upper bits and
// buffered in a 2-entry FIFO, so nothing combinational reaches the output side.
module arbiter #(
  parameter  int nbits      = 32,
  parameter  int ninputs    = 8,
  localparam int addr_nbits = $clog2(ninputs)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ninputs-1:0]           istream_val,
  input  logic [nbits-1:0]             istream_msg [ninputs],
  output logic [ninputs-1:0]           istream_rdy,
  output logic                         ostream_val,
  output logic [addr_nbits+nbits-1:0]  ostream_msg,
  input  logic                         ostream_rdy
);

  localparam int ow = addr_nbits + nbits;

  // Priority pointer: the index searched first when picking a grant.
  logic [addr_nbits-1:0] ptr_q;
  logic [addr_nbits-1:0] ptr_d;

  // Two-entry FIFO storage and bookkeeping.
  logic [ow-1:0] mem_q [2];
  logic          wr_ptr_q;
  logic          wr_ptr_d;
  logic          rd_ptr_q;
  logic          rd_ptr_d;
  logic [1:0]    count_q;
  logic [1:0]    count_d;

  logic                  grant_any;
  logic [addr_nbits-1:0] grant_idx;
  logic [ninputs-1:0]    grant_oh;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;
  logic [ow-1:0]         enq_entry;

  // Full means "cannot accept this cycle"; a same-cycle pop does not free a slot.
  assign fifo_full = (count_q == 2'd2);

  // Round-robin search starting at ptr_q, wrapping modulo ninputs.
  always_comb begin
    logic [addr_nbits:0] sum;
    grant_any = 1'b0;
    grant_idx = '0;
    sum       = '0;
    for (int k = 0; k < ninputs; k++) begin
      sum = {1'b0, ptr_q} + (addr_nbits + 1)'(k);
      if (sum >= (addr_nbits + 1)'(ninputs)) begin
        sum = sum - (addr_nbits + 1)'(ninputs);
      end
      if (!grant_any && istream_val[sum[addr_nbits-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = sum[addr_nbits-1:0];
      end
    end
  end

  // Only the granted input may see ready, and never during reset or when full.
  for (genvar gi = 0; gi < ninputs; gi++) begin : g_rdy
    assign grant_oh[gi]    = grant_any && (grant_idx == addr_nbits'(gi));
    assign istream_rdy[gi] = grant_oh[gi] && !fifo_full && !reset;
  end

  // A grant implies the granted valid is high, so ready alone marks a transfer.
  assign push      = grant_any && !fifo_full && !reset;
  assign enq_entry = {grant_idx, istream_msg[grant_idx]};

  // Output is driven purely from FIFO state; reset masks it in the reset cycle.
  assign ostream_val = (count_q != 2'd0) && !reset;
  assign ostream_msg = mem_q[rd_ptr_q];
  assign pop         = ostream_val && ostream_rdy;

  // Next-state for pointer and FIFO occupancy.
  always_comb begin
    ptr_d    = ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      if (grant_idx == addr_nbits'(ninputs - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + addr_nbits'(1);
      end
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state registers; reset discards any in-flight entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      ptr_q    <= ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO payload storage; contents are only meaningful while counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= enq_entry;
    end
  end

endmodule

// File: doc/arbiter.md
# arbiter

Merges `ninputs` valid/ready streams into one output stream, the inverse of the router. Each accepted message is prefixed with its source port index in the upper `$clog2(ninputs)` bits, so a downstream router can steer a reply back by index. Arbitration is round-robin; accepted messages pass through an internal 2-entry FIFO before leaving on the output stream.

## Interface
- `nbits`, default 32: payload width of each input message.
- `ninputs`, default 8: number of input streams; must be at least 2.
- Derived `addr_nbits` = `$clog2(ninputs)`: width of the prepended source index.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `istream_val`  input  1 x [0:ninputs-1]  per-input valid.
- `istream_msg`  input  nbits x [0:ninputs-1]  per-input payload.
- `istream_rdy`  output  1 x [0:ninputs-1]  per-input ready.
- `ostream_val`  output  1  output valid.
- `ostream_msg`  output  addr_nbits+nbits  output message, formatted `{src_index, payload}`.
- `ostream_rdy`  input  1  output ready.

## Operation
- **Transfer rule.** A transfer on any stream happens only in a cycle where val and rdy are both high.
- **Priority pointer.** `ptr` is `addr_nbits` wide and resets to 0.
- **Grant.** Grant goes to the first index i with `istream_val[i]` high, searching `ptr`, `ptr+1`, … and wrapping modulo `ninputs`.
  - The grant is combinational from `istream_val` and `ptr` only.
  - No input valid means no grant.
- **Input ready.** `istream_rdy[i]` = (i == grant) AND FIFO not full.
  - At most one `istream_rdy` is high in any cycle.
  - Every non-granted input sees rdy = 0.
- **Pointer update.** On a transfer from input g, `ptr` becomes (g+1) mod `ninputs` at the next edge.
  - With no transfer, `ptr` holds.
  - When g = `ninputs`-1, `ptr` wraps to 0.
- **Enqueue.** On each input transfer, `{g[addr_nbits-1:0], istream_msg[g]}` is written into the FIFO.
- **FIFO.**
  - Depth 2, in-order.
  - Output valid = FIFO non-empty; `ostream_msg` = head entry.
  - The head is popped on an `ostream_val` && `ostream_rdy` transfer.
- **Full FIFO.** Enqueue readiness is "not full" only. A full FIFO blocks all inputs even if a dequeue happens in the same cycle; there is no pipelined enqueue.
- **Simultaneous enqueue and dequeue.**
  - Non-empty and not full: occupancy stays the same.
  - Empty: the new entry is written, but the dequeue cannot occur because `ostream_val` is 0 that cycle.
- **Valid stability.** Inputs must hold val and msg until accepted. The arbiter may change its grant while an input waits; that input's val must stay high.
- **Reset.**
  - FIFO is emptied, `ptr` = 0.
  - `ostream_val` = 0 and all `istream_rdy` = 0 during the reset cycle.
  - `ostream_msg` is don't-care while `ostream_val` = 0.
- **Reset mid-operation.** In-flight FIFO contents are discarded, with no output transfer in the reset cycle.

## Timing
- **Latency.** 1 cycle. A message accepted at edge t is presented with `ostream_val` = 1 in the cycle after t. There is no combinational path from input to output.
- **Ready fall.** `istream_rdy` falls in the cycle after the FIFO reaches 2 entries.
- **Ready return.** Readiness returns the cycle after a dequeue.
- **Throughput.** Sustained rate is 1 message per cycle when `ostream_rdy` is held high.
- **Combinational paths.**
  - `istream_val` -> `istream_rdy` is a combinational path.
  - No path exists from `ostream_rdy` to `istream_rdy` within the same cycle.

## Test plan
- **Reset state.** Hold reset for 2 cycles, then release with all inputs idle.
  - Required: `ostream_val` = 0 and all `istream_rdy` = 0 during reset.
  - Required: `ostream_val` stays 0 after reset.
- **Single source.** `nbits` = 32, `ninputs` = 8. Input 5 sends 0xDEADBEEF with `ostream_rdy` = 1.
  - Required: the next cycle shows `ostream_val` = 1 and `ostream_msg` = {3'd5, 32'hDEADBEEF}.
  - Required: `ptr` becomes 6.
- **Round-robin fairness.** After reset, inputs 0, 3 and 7 all stay valid, each with infinite messages, and `ostream_rdy` = 1.
  - Required output index order: 0, 3, 7, 0, 3, 7. No input is starved.
- **Wrap-around.** Inputs 7 and 1 are valid with `ptr` = 7.
  - Required grant order: 7, then 1.
- **Backpressure and full FIFO.** Hold `ostream_rdy` = 0 with input 2 valid, streaming 0xA, 0xB, 0xC.
  - Required: 0xA and 0xB are accepted; `istream_rdy[2]` = 0 from the third cycle onward.
  - Then raise `ostream_rdy`. Required: outputs appear in order 0xA, 0xB, 0xC, with no loss or duplication.
- **Reset mid-operation.** Reset is asserted with 2 messages in the FIFO.
  - Required: the next cycle shows `ostream_val` = 0 and `ptr` = 0.
  - Required: a later input 4 message is the first output.
